matrix_loader: RTL
==================

# matrix_loader

Front-end write stage for the matrix storage block. It takes a requested m×n size and a ready/valid stream of element values, range-checks each value, and obtains a slot ID through the storage allocation interface. It then writes the elements row-major through the storage write port and finally commits the dimensions, which marks the slot valid. It sits between the input parser (UART/keypad number stream) and the matrix storage block.

## Interface
- DATA_W, 32, element width
- MAX_DIM, 5, largest legal m and n
- VAL_MAX, 9, largest legal element value (unsigned)
- ALLOC_TO, 15, cycles to wait for alloc_valid before error
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- start  in  1  pulse; begin a load with cfg_m/cfg_n (ignored unless IDLE)
- cfg_m, cfg_n  in  4 each  requested rows/cols
- abort  in  1  cancel current load
- fill  in  1  pad remaining elements with 0
- in_valid  in  1  element valid
- in_data  in  DATA_W  element value
- in_ready  out  1  element accepted when in_valid&&in_ready
- alloc_req  out  1  one-cycle allocation request
- alloc_m, alloc_n  out  4 each  size sent with request
- alloc_valid  in  1  storage returned an ID
- alloc_id  in  7  returned ID
- write_en  out  1  element write strobe
- id_w  out  7  slot being written
- row_w, col_w  out  4 each  element position
- data_in  out  DATA_W  element value to storage
- dim_we  out  1  dimension commit strobe
- dim_write_id  out  7  slot being committed
- dim_write_m, dim_write_n  out  4 each  committed dimensions
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse: load committed
- loaded_id  out  7  ID of last committed matrix (holds)
- err  out  1  one-cycle error pulse
- err_code  out  2  1=bad dim, 2=alloc timeout, 3=value out of range (holds until next err)

## Operation
- States: IDLE, ALLOC, WAIT_ID, LOAD, PAD, COMMIT.
- IDLE: start with 1≤cfg_m≤MAX_DIM and 1≤cfg_n≤MAX_DIM latches m, n and goes to ALLOC. Any other size raises err with code 1 and stays in IDLE.
- ALLOC: drives alloc_req=1 for exactly one cycle with alloc_m/n=latched values, then goes to WAIT_ID and clears a timeout counter.
- WAIT_ID: alloc_valid latches alloc_id as slot ID, clears row/col to 0, and goes to LOAD. After ALLOC_TO cycles without alloc_valid: err code 2, go to IDLE.
- LOAD: in_ready=1.
  - On handshake with in_data≤VAL_MAX: write (slot, row, col, in_data). col increments; at col==n-1 col wraps to 0 and row increments. The last element (row m-1, col n-1) moves to COMMIT.
  - On handshake with in_data>VAL_MAX: no write, err code 3, go to IDLE.
  - fill=1 in LOAD moves to PAD. A handshake in the same cycle is processed first, then fill takes effect. If that element was the last, go to COMMIT instead.
- PAD: in_ready=0. Writes 0 at the current position each cycle, advancing as in LOAD; after the last position go to COMMIT.
- COMMIT: dim_we=1 with slot ID, m, n; done=1; loaded_id←slot ID; go to IDLE.
- abort in any non-IDLE state: go to IDLE next cycle; no further writes, no dim_we, no err. A slot whose allocation was abandoned is never committed, so it stays invalid.
- rst mid-load behaves like abort and clears all outputs.
- Comparisons are unsigned across the full DATA_W. Row/col counters are 4 bits and never exceed MAX_DIM-1.

## Timing
- All outputs are registered except in_ready, which decodes directly from state LOAD.
- Reset values: every output is 0; state IDLE.
- start accepted at cycle t: alloc_req high at t+1 only.
- Storage answers at t+2; LOAD is active from t+3.
- Handshake at cycle c: write_en and its id/row/col/data are valid at c+1 for one cycle.
- One element per cycle is sustained in LOAD and in PAD.
- Last handshake at cycle c: final write_en at c+1, dim_we and done at c+2, busy low at c+3.
- The write strobe and dim_we are never asserted in the same cycle.
- err is a one-cycle pulse one cycle after the causing event; busy falls in the same cycle as err.
- start while busy is ignored.

## Test plan
- 2×3 load, values 1..6 streamed back-to-back, storage gives ID 4:
  - writes go to (4,0,0)=1 … (4,1,2)=6 on consecutive cycles;
  - then dim_we with id 4, m=2, n=3; done=1; loaded_id=4.
- 3×3 load, 4 values sent, then fill:
  - 4 data writes, then 5 zero writes at (1,1)…(2,2) on consecutive cycles;
  - then dim_we with m=3, n=3.
- start with cfg_m=0, cfg_n=2, and separately cfg_m=6, cfg_n=1:
  - err pulse, err_code=1, no alloc_req, busy stays 0.
- 2×2 load, second value 12:
  - one write only, then err code 3, no dim_we, busy 0 afterwards.
- alloc_valid withheld:
  - err code 2 exactly ALLOC_TO cycles after entering WAIT_ID.
- abort after 3 of 4 elements, and rst after 3 of 4 elements:
  - no dim_we, no done;
  - a subsequent 1×1 load of value 7 succeeds.

Source files
------------

// File: rtl/matrix_loader.sv
// Matrix loader: checks the requested size, obtains a storage slot, writes the
// elements row-major (with optional zero padding) and commits the dimensions.
module matrix_loader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_DIM  = 5,
  parameter int unsigned VAL_MAX  = 9,
  parameter int unsigned ALLOC_TO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_m,
  input  logic [3:0]        cfg_n,
  input  logic              abort,
  input  logic              fill,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              alloc_req,
  output logic [3:0]        alloc_m,
  output logic [3:0]        alloc_n,
  input  logic              alloc_valid,
  input  logic [6:0]        alloc_id,
  output logic              write_en,
  output logic [6:0]        id_w,
  output logic [3:0]        row_w,
  output logic [3:0]        col_w,
  output logic [DATA_W-1:0] data_in,
  output logic              dim_we,
  output logic [6:0]        dim_write_id,
  output logic [3:0]        dim_write_m,
  output logic [3:0]        dim_write_n,
  output logic              busy,
  output logic              done,
  output logic [6:0]        loaded_id,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DIM_W = 4;
  localparam int unsigned ID_W  = 7;
  localparam int unsigned TO_W  = $clog2(ALLOC_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_WAIT_ID,
    S_LOAD,
    S_PAD,
    S_COMMIT
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  m_q;
  logic [DIM_W-1:0]  n_q;
  logic [ID_W-1:0]   slot;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [TO_W-1:0]   to_cnt;

  logic              dim_ok;
  logic              val_ok;
  logic              hs;
  logic              last_pos;
  logic [DIM_W-1:0]  m_last;
  logic [DIM_W-1:0]  n_last;
  logic [DIM_W-1:0]  row_nx;
  logic [DIM_W-1:0]  col_nx;

  assign in_ready = (state == S_LOAD);
  assign hs       = in_valid && in_ready;

  // Size/value checks and the row-major position step; the position holds at
  // the last element so the counters never leave the matrix.
  always_comb begin
    dim_ok   = (cfg_m != '0) && (cfg_m <= DIM_W'(MAX_DIM)) &&
               (cfg_n != '0) && (cfg_n <= DIM_W'(MAX_DIM));
    val_ok   = (in_data <= DATA_W'(VAL_MAX));
    m_last   = DIM_W'(m_q - DIM_W'(1));
    n_last   = DIM_W'(n_q - DIM_W'(1));
    last_pos = (row == m_last) && (col == n_last);
    row_nx   = row;
    col_nx   = col;
    if (!last_pos) begin
      if (col == n_last) begin
        col_nx = '0;
        row_nx = DIM_W'(row + DIM_W'(1));
      end else begin
        col_nx = DIM_W'(col + DIM_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      m_q          <= '0;
      n_q          <= '0;
      slot         <= '0;
      row          <= '0;
      col          <= '0;
      to_cnt       <= '0;
      alloc_req    <= 1'b0;
      alloc_m      <= '0;
      alloc_n      <= '0;
      write_en     <= 1'b0;
      id_w         <= '0;
      row_w        <= '0;
      col_w        <= '0;
      data_in      <= '0;
      dim_we       <= 1'b0;
      dim_write_id <= '0;
      dim_write_m  <= '0;
      dim_write_n  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      loaded_id    <= '0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      alloc_req <= 1'b0;
      alloc_m   <= '0;
      alloc_n   <= '0;
      write_en  <= 1'b0;
      dim_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // Abandoned slot is simply never committed.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
            if (start) begin
              if (dim_ok) begin
                m_q       <= cfg_m;
                n_q       <= cfg_n;
                alloc_req <= 1'b1;
                alloc_m   <= cfg_m;
                alloc_n   <= cfg_n;
                busy      <= 1'b1;
                state     <= S_ALLOC;
              end else begin
                err      <= 1'b1;
                err_code <= 2'd1;
              end
            end
          end

          S_ALLOC: begin
            to_cnt <= '0;
            state  <= S_WAIT_ID;
          end

          S_WAIT_ID: begin
            if (alloc_valid) begin
              slot  <= alloc_id;
              row   <= '0;
              col   <= '0;
              state <= S_LOAD;
            end else if (to_cnt == TO_W'(ALLOC_TO - 1)) begin
              err      <= 1'b1;
              err_code <= 2'd2;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              to_cnt <= TO_W'(to_cnt + TO_W'(1));
            end
          end

          // A handshake in the same cycle as fill is taken before padding starts.
          S_LOAD: begin
            if (hs && !val_ok) begin
              err      <= 1'b1;
              err_code <= 2'd3;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (hs) begin
              write_en <= 1'b1;
              id_w     <= slot;
              row_w    <= row;
              col_w    <= col;
              data_in  <= in_data;
              row      <= row_nx;
              col      <= col_nx;
              if (last_pos) begin
                state <= S_COMMIT;
              end else if (fill) begin
                state <= S_PAD;
              end
            end else if (fill) begin
              state <= S_PAD;
            end
          end

          S_PAD: begin
            write_en <= 1'b1;
            id_w     <= slot;
            row_w    <= row;
            col_w    <= col;
            data_in  <= '0;
            row      <= row_nx;
            col      <= col_nx;
            if (last_pos) begin
              state <= S_COMMIT;
            end
          end

          // busy stays high through the commit strobe and drops the cycle after.
          S_COMMIT: begin
            dim_we       <= 1'b1;
            dim_write_id <= slot;
            dim_write_m  <= m_q;
            dim_write_n  <= n_q;
            done         <= 1'b1;
            loaded_id    <= slot;
            state        <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
